dac_spi_scheduler: RTL and testbench
====================================

# dac_spi_scheduler

Controller that owns the single 24-bit SPI DAC sender and shares it between two requesters: the audio sample path (priority port A) and an auxiliary/config path (port B). After reset it issues one DAC configuration word, then generates the sample-rate start tick that drives the sample output path. It sits between the sample formatter/aux logic and the DAC SPI serialiser, and it sequences the serialiser's Send/Ready handshake on their behalf.

## Interface
- SAMPLE_DIVIDER, 1000: clock cycles per sample tick. Legal range is 2..65535.
- INIT_WORD, 24'h380001: word sent once after reset (DAC internal reference enable).
- A_BURST, 2: maximum consecutive A transfers while B is pending.
- ACK_TIMEOUT, 255: cycles to wait for the serialiser to accept (Ready low) before aborting.

Ports:
- i_Clock  in  1  system clock
- i_Reset_n  in  1  asynchronous, active-low reset
- o_Sample_Tick  out  1  one-cycle pulse every SAMPLE_DIVIDER cycles, only once o_Init_Done=1
- i_A_Req  in  1  one-cycle request pulse, audio word
- i_A_Data  in  24  audio word; channel byte plus 16-bit sample; captured when i_A_Req=1
- o_A_Done  out  1  one-cycle pulse when the A word has fully shifted out
- i_B_Req  in  1  one-cycle request pulse, aux word
- i_B_Data  in  24  aux word; captured when i_B_Req=1
- o_B_Done  out  1  one-cycle pulse when the B word has fully shifted out
- o_DAC_Data  out  24  word presented to the serialiser
- o_DAC_Send  out  1  send request to the serialiser
- i_DAC_Ready  in  1  high when the serialiser is idle
- o_Init_Done  out  1  high once INIT_WORD has completed; stays high until reset
- o_A_Overrun  out  1  sticky; set when an A request overwrites a pending, unsent A word
- o_Timeout  out  1  sticky; set when the serialiser fails to accept within ACK_TIMEOUT

## Operation
- Each port has a one-deep pending register (flag plus 24-bit data).
  - A request pulse loads the register and sets the flag.
  - If the flag is already set, the new data overwrites the old data. For port A this also sets o_A_Overrun. For port B it is silent; newest wins.
  - When a request pulse and a grant of the same port fall in the same cycle, the grant takes the old data and the new data stays pending.
- State machine states: INIT, IDLE, SEND, ACCEPT, DRAIN.
  - INIT, entered from reset: load INIT_WORD, then go to SEND with source=INIT.
  - IDLE, when i_DAC_Ready=1: pick a source.
    - A wins if A is pending and (B is not pending or the A burst count is below A_BURST).
    - Otherwise B wins if B is pending.
    - The winner's data goes to o_DAC_Data, its pending flag clears, and the state goes to SEND.
  - SEND: o_DAC_Send=1, go to ACCEPT.
  - ACCEPT: hold o_DAC_Send=1 until i_DAC_Ready=0, then drop Send and go to DRAIN.
    - If ACK_TIMEOUT cycles elapse first: drop Send, set o_Timeout, return to IDLE with no Done pulse.
    - A timed-out INIT still sets o_Init_Done, so the design keeps running.
  - DRAIN: wait for i_DAC_Ready=1, then pulse the Done for the source (none for INIT), and go to IDLE.
    - For INIT, o_Init_Done is set instead of a Done pulse.
- A burst count:
  - Increments on each A grant and saturates at A_BURST.
  - Clears on each B grant, and whenever B is not pending at A-grant time (the count then becomes 1).
- Sample tick counter: counts 0..SAMPLE_DIVIDER-1 and wraps. It holds at 0 until o_Init_Done=1. The tick pulses on the wrap cycle.

## Timing
- Reset (async, asserted) sets all of these to 0 immediately:
  - o_DAC_Send, o_DAC_Data, all Done pulses, o_Sample_Tick, o_Init_Done, o_A_Overrun, o_Timeout
  - pending flags, burst count, tick counter
- The state goes to INIT on reset. Release is synchronous to i_Clock: the first INIT cycle is the first edge after deassertion.
- Reset asserted mid-transfer drops o_DAC_Send at once. The serialiser shares this reset.
- All outputs are registered.
- Latency, idle serialiser, A request at edge N:
  - o_DAC_Data valid and o_DAC_Send=1 from edge N+2.
  - Send is held until the cycle after the first i_DAC_Ready=0 is sampled.
  - o_A_Done appears one cycle after i_DAC_Ready returns high.
- A and B requests in the same cycle while idle: A is served first, then B, unless the burst limit forces B first.
- Back-to-back: the next grant can start in the cycle after Done, giving at least 2 idle cycles between Send pulses.
- Timeout count starts at SEND. Timeout is declared when the count reaches ACK_TIMEOUT with Ready still high.
- The first o_Sample_Tick comes SAMPLE_DIVIDER cycles after o_Init_Done rises.

## Test plan
- Reset release with a serialiser model (Ready low 26 cycles after Send) -> exactly one transfer of 24'h380001, o_Init_Done=1 after Ready returns, first o_Sample_Tick 1000 cycles later, then every 1000 cycles.
- A=24'h31ABCD and B=24'h32_1234 pulsed in the same cycle -> 24'h31ABCD sent first with o_A_Done, then 24'h321234 with o_B_Done, and no overrun.
- A pulsed 4 times (L/R/L/R) while B is pending, A_BURST=2 -> send order A,A,B,A,A.
- Two A pulses 3 cycles apart while the serialiser is busy -> only the second word is sent, o_A_Overrun=1 and sticky, exactly one o_A_Done.
- Serialiser holds Ready high forever after Send -> o_DAC_Send drops after 255 cycles, o_Timeout=1, no Done pulse, a following B request is still served once Ready behaves.
- i_Reset_n pulsed low during ACCEPT -> o_DAC_Send=0 in the same cycle without waiting for a clock edge, pending flags cleared, INIT_WORD resent after release.

Source files
------------

// File: rtl/dac_spi_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | dac_spi_scheduler: shares one 24-bit SPI DAC sender between an audio port   |
// | (A, priority with burst limit) and an aux port (B); sends INIT_WORD first.  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module dac_spi_scheduler #(
    parameter int          SAMPLE_DIVIDER = 1000,
    parameter logic [23:0] INIT_WORD      = 24'h380001,
    parameter int          A_BURST        = 2,
    parameter int          ACK_TIMEOUT    = 255
) (
    input  logic        i_Clock,
    input  logic        i_Reset_n,
    output logic        o_Sample_Tick,
    input  logic        i_A_Req,
    input  logic [23:0] i_A_Data,
    output logic        o_A_Done,
    input  logic        i_B_Req,
    input  logic [23:0] i_B_Data,
    output logic        o_B_Done,
    output logic [23:0] o_DAC_Data,
    output logic        o_DAC_Send,
    input  logic        i_DAC_Ready,
    output logic        o_Init_Done,
    output logic        o_A_Overrun,
    output logic        o_Timeout
);

    localparam logic [15:0] TICK_LAST = 16'(SAMPLE_DIVIDER - 1);
    localparam logic [15:0] ACK_LIMIT = 16'(ACK_TIMEOUT);
    localparam logic [7:0]  BURST_MAX = 8'(A_BURST);

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_SEND   = 3'd2,
        ST_ACCEPT = 3'd3,
        ST_DRAIN  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SRC_INIT = 2'd0,
        SRC_A    = 2'd1,
        SRC_B    = 2'd2
    } src_t;

    state_t      state_q, state_d;
    src_t        src_q, src_d;
    logic [23:0] dac_data_q, dac_data_d;
    logic        send_q, send_d;
    logic        a_pend_q, a_pend_d;
    logic [23:0] a_data_q, a_data_d;
    logic        b_pend_q, b_pend_d;
    logic [23:0] b_data_q, b_data_d;
    logic        a_done_q, a_done_d;
    logic        b_done_q, b_done_d;
    logic        init_done_q, init_done_d;
    logic        overrun_q, overrun_d;
    logic        timeout_q, timeout_d;
    logic [7:0]  burst_q, burst_d;
    logic [15:0] ack_cnt_q, ack_cnt_d;
    logic [15:0] tick_cnt_q, tick_cnt_d;
    logic        tick_q, tick_d;
    logic        grant_a, grant_b;

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dac_data_d  = dac_data_q;
        send_d      = send_q;
        a_pend_d    = a_pend_q;
        a_data_d    = a_data_q;
        b_pend_d    = b_pend_q;
        b_data_d    = b_data_q;
        a_done_d    = 1'b0;
        b_done_d    = 1'b0;
        init_done_d = init_done_q;
        overrun_d   = overrun_q;
        timeout_d   = timeout_q;
        burst_d     = burst_q;
        ack_cnt_d   = ack_cnt_q;
        tick_cnt_d  = tick_cnt_q;
        tick_d      = 1'b0;
        grant_a     = 1'b0;
        grant_b     = 1'b0;

        case (state_q)
            ST_INIT: begin
                dac_data_d = INIT_WORD;
                src_d      = SRC_INIT;
                ack_cnt_d  = 16'd0;
                state_d    = ST_SEND;
            end
            ST_IDLE: begin
                if (i_DAC_Ready) begin
                    if (a_pend_q && (!b_pend_q || (burst_q < BURST_MAX))) begin
                        grant_a = 1'b1;
                    end else if (b_pend_q) begin
                        grant_b = 1'b1;
                    end
                end
                if (grant_a) begin
                    dac_data_d = a_data_q;
                    src_d      = SRC_A;
                    burst_d    = b_pend_q ? (burst_q + 8'd1) : 8'd1;
                    ack_cnt_d  = 16'd0;
                    state_d    = ST_SEND;
                end else if (grant_b) begin
                    dac_data_d = b_data_q;
                    src_d      = SRC_B;
                    burst_d    = 8'd0;
                    ack_cnt_d  = 16'd0;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                send_d    = 1'b1;
                ack_cnt_d = 16'd1;
                state_d   = ST_ACCEPT;
            end
            ST_ACCEPT: begin
                if (!i_DAC_Ready) begin
                    send_d  = 1'b0;
                    state_d = ST_DRAIN;
                end else if (ack_cnt_q >= ACK_LIMIT) begin
                    // Abort: a stuck init must not stall the design forever.
                    send_d    = 1'b0;
                    timeout_d = 1'b1;
                    if (src_q == SRC_INIT) begin
                        init_done_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else begin
                    ack_cnt_d = ack_cnt_q + 16'd1;
                end
            end
            ST_DRAIN: begin
                if (i_DAC_Ready) begin
                    case (src_q)
                        SRC_A:   a_done_d    = 1'b1;
                        SRC_B:   b_done_d    = 1'b1;
                        default: init_done_d = 1'b1;
                    endcase
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase

        // A grant in the same cycle as a request consumes the old word.
        if (grant_a) begin
            a_pend_d = 1'b0;
        end
        if (i_A_Req) begin
            a_pend_d = 1'b1;
            a_data_d = i_A_Data;
            if (a_pend_q && !grant_a) begin
                overrun_d = 1'b1;
            end
        end
        if (grant_b) begin
            b_pend_d = 1'b0;
        end
        if (i_B_Req) begin
            b_pend_d = 1'b1;
            b_data_d = i_B_Data;
        end

        if (init_done_q) begin
            if (tick_cnt_q == TICK_LAST) begin
                tick_cnt_d = 16'd0;
                tick_d     = 1'b1;
            end else begin
                tick_cnt_d = tick_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q     <= ST_INIT;
            src_q       <= SRC_INIT;
            dac_data_q  <= 24'd0;
            send_q      <= 1'b0;
            a_pend_q    <= 1'b0;
            a_data_q    <= 24'd0;
            b_pend_q    <= 1'b0;
            b_data_q    <= 24'd0;
            a_done_q    <= 1'b0;
            b_done_q    <= 1'b0;
            init_done_q <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
            burst_q     <= 8'd0;
            ack_cnt_q   <= 16'd0;
            tick_cnt_q  <= 16'd0;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dac_data_q  <= dac_data_d;
            send_q      <= send_d;
            a_pend_q    <= a_pend_d;
            a_data_q    <= a_data_d;
            b_pend_q    <= b_pend_d;
            b_data_q    <= b_data_d;
            a_done_q    <= a_done_d;
            b_done_q    <= b_done_d;
            init_done_q <= init_done_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
            burst_q     <= burst_d;
            ack_cnt_q   <= ack_cnt_d;
            tick_cnt_q  <= tick_cnt_d;
            tick_q      <= tick_d;
        end
    end

    assign o_Sample_Tick = tick_q;
    assign o_A_Done      = a_done_q;
    assign o_B_Done      = b_done_q;
    assign o_DAC_Data    = dac_data_q;
    assign o_DAC_Send    = send_q;
    assign o_Init_Done   = init_done_q;
    assign o_A_Overrun   = overrun_q;
    assign o_Timeout     = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_dac_spi_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_dac_spi_scheduler: directed scenarios against a serialiser model with an |
// | expected-word scoreboard. Revision: 1.0                                     |
// +-----------------------------------------------------------------------------+
module tb_dac_spi_scheduler;

    localparam int DIV      = 1000;
    localparam int BUSY_LEN = 26;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick;
    logic        a_req = 1'b0;
    logic [23:0] a_data = 24'd0;
    logic        a_done;
    logic        b_req = 1'b0;
    logic [23:0] b_data = 24'd0;
    logic        b_done;
    logic [23:0] dac_data;
    logic        dac_send;
    logic        dac_ready = 1'b1;
    logic        init_done;
    logic        overrun;
    logic        timeout;

    dac_spi_scheduler dut (
        .i_Clock       (clk),
        .i_Reset_n     (rst_n),
        .o_Sample_Tick (tick),
        .i_A_Req       (a_req),
        .i_A_Data      (a_data),
        .o_A_Done      (a_done),
        .i_B_Req       (b_req),
        .i_B_Data      (b_data),
        .o_B_Done      (b_done),
        .o_DAC_Data    (dac_data),
        .o_DAC_Send    (dac_send),
        .i_DAC_Ready   (dac_ready),
        .o_Init_Done   (init_done),
        .o_A_Overrun   (overrun),
        .o_Timeout     (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] data;
        int          src;   // 0 init, 1 A, 2 B
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   inflight = -1;
    int   acc_cnt = 0;
    int   a_done_cnt = 0;
    int   b_done_cnt = 0;
    int   tick_total = 0;
    int   tick_gap = 0;
    int   busy = 0;
    bit   hang = 1'b0;
    bit   init_seen = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic void push_exp(input logic [23:0] d, input int s);
        exp_t e;
        e.data = d;
        e.src  = s;
        exp_q.push_back(e);
    endfunction

    // Serialiser model plus scoreboard consumer and Done/tick monitors.
    always @(negedge clk) begin
        if (!rst_n) begin
            dac_ready = 1'b1;
            busy      = 0;
            inflight  = -1;
            init_seen = 1'b0;
            tick_gap  = 0;
        end else begin
            if (busy > 0) begin
                busy--;
                if (busy == 0) dac_ready = 1'b1;
            end else if (dac_send && dac_ready && !hang) begin
                exp_t e;
                dac_ready = 1'b0;
                busy      = BUSY_LEN;
                acc_cnt++;
                check("xfer_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("xfer_data", dac_data, e.data);
                    inflight = e.src;
                end
            end
            if (a_done) begin
                a_done_cnt++;
                check("a_done_src", inflight, 1);
                inflight = -1;
            end
            if (b_done) begin
                b_done_cnt++;
                check("b_done_src", inflight, 2);
                inflight = -1;
            end
            if (init_done && !init_seen) begin
                init_seen = 1'b1;
                check("init_done_src", inflight, 0);
                inflight = -1;
            end
            if (tick) begin
                check("tick_after_init", init_done, 1);
                check("tick_interval", tick_gap, DIV);
                tick_total++;
                tick_gap = 1;
            end else if (init_done) begin
                tick_gap++;
            end
        end
    end

    task automatic pulse(input logic pa, input logic [23:0] da, input logic pb, input logic [23:0] db);
        @(negedge clk);
        a_req = pa;
        b_req = pb;
        if (pa) a_data = da;
        if (pb) b_data = db;
        @(negedge clk);
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    task automatic wait_accept(input string tag);
        int n0 = acc_cnt;
        for (int i = 0; i < 300 && acc_cnt == n0; i++) @(negedge clk);
        check(tag, acc_cnt != n0, 1);
    endtask

    task automatic wait_quiet(input string tag);
        for (int i = 0; i < 2000 && !(exp_q.size() == 0 && inflight < 0); i++) @(negedge clk);
        check(tag, exp_q.size() == 0 && inflight < 0, 1);
    endtask

    task automatic wait_send(input string tag);
        for (int i = 0; i < 50 && !dac_send; i++) @(negedge clk);
        check(tag, dac_send, 1);
    endtask

    initial begin
        int n;
        int acc0;
        int ad0;
        int bd0;

        // Reset state and init word
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {dac_send, tick, a_done, b_done, init_done, overrun, timeout}, 0);
        check("rst_data", dac_data, 0);
        push_exp(24'h380001, 0);
        rst_n = 1'b1;
        wait_quiet("init_quiet");
        check("init_done", init_done, 1);
        check("init_xfer_count", acc_cnt, 1);

        // A and B together: A first, then B; also request-to-send latency
        ad0 = a_done_cnt;
        bd0 = b_done_cnt;
        push_exp(24'h31ABCD, 1);
        push_exp(24'h321234, 2);
        pulse(1'b1, 24'h31ABCD, 1'b1, 24'h321234);
        n = 0;
        while (!dac_send && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, 2);
        check("latency_data", dac_data, 24'h31ABCD);
        wait_quiet("ab_quiet");
        check("ab_a_done", a_done_cnt - ad0, 1);
        check("ab_b_done", b_done_cnt - bd0, 1);
        check("ab_no_overrun", overrun, 0);

        // Burst limit: expected order A1, A2, B, A3, A4
        push_exp(24'h300001, 1);
        push_exp(24'h310002, 1);
        push_exp(24'h32B0B0, 2);
        push_exp(24'h300003, 1);
        push_exp(24'h310004, 1);
        pulse(1'b1, 24'h300001, 1'b1, 24'h32B0B0);
        wait_accept("burst_acc1");
        pulse(1'b1, 24'h310002, 1'b0, 24'h0);
        wait_accept("burst_acc2");
        pulse(1'b1, 24'h300003, 1'b0, 24'h0);
        wait_accept("burst_acc3");
        wait_accept("burst_acc4");
        pulse(1'b1, 24'h310004, 1'b0, 24'h0);
        wait_quiet("burst_quiet");
        check("burst_no_overrun", overrun, 0);

        // Overrun: two A requests 3 cycles apart while serialiser is busy
        push_exp(24'h325555, 2);
        pulse(1'b0, 24'h0, 1'b1, 24'h325555);
        wait_accept("ovr_busy");
        ad0 = a_done_cnt;
        push_exp(24'h30BBBB, 1);
        @(negedge clk);
        a_req  = 1'b1;
        a_data = 24'h30AAAA;
        @(negedge clk);
        a_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a_req  = 1'b1;
        a_data = 24'h30BBBB;
        @(negedge clk);
        a_req = 1'b0;
        @(negedge clk);
        check("overrun_set", overrun, 1);
        wait_quiet("ovr_quiet");
        check("overrun_sticky", overrun, 1);
        check("ovr_a_done_once", a_done_cnt - ad0, 1);

        // Timeout: serialiser never accepts
        hang = 1'b1;
        ad0 = a_done_cnt;
        bd0 = b_done_cnt;
        acc0 = acc_cnt;
        check("tmo_clear", timeout, 0);
        pulse(1'b1, 24'h30DEAD, 1'b0, 24'h0);
        wait_send("tmo_send");
        n = 0;
        while (dac_send && n < 400) begin
            n++;
            @(negedge clk);
        end
        check("tmo_send_len", n, 255);
        check("tmo_flag", timeout, 1);
        repeat (40) @(negedge clk);
        check("tmo_no_done", (a_done_cnt - ad0) + (b_done_cnt - bd0), 0);
        check("tmo_no_accept", acc_cnt - acc0, 0);
        hang = 1'b0;
        bd0 = b_done_cnt;
        push_exp(24'h32C0DE, 2);
        pulse(1'b0, 24'h0, 1'b1, 24'h32C0DE);
        wait_quiet("tmo_recover_quiet");
        check("tmo_recover_b_done", b_done_cnt - bd0, 1);
        check("tmo_sticky", timeout, 1);

        // Async reset in ACCEPT with an A word pending
        hang = 1'b1;
        pulse(1'b0, 24'h0, 1'b1, 24'h327777);
        wait_send("rst_send");
        pulse(1'b1, 24'h305A5A, 1'b0, 24'h0);
        check("rst_still_sending", dac_send, 1);
        #2;
        rst_n = 1'b0;
        hang  = 1'b0;
        #1;
        check("rst_send_async", dac_send, 0);
        check("rst_flags_async", {init_done, overrun, timeout}, 0);
        check("rst_data_async", dac_data, 0);
        repeat (2) @(negedge clk);
        acc0 = acc_cnt;
        push_exp(24'h380001, 0);
        rst_n = 1'b1;
        wait_quiet("reinit_quiet");
        check("reinit_done", init_done, 1);
        repeat (100) @(negedge clk);
        check("reinit_single_xfer", acc_cnt - acc0, 1);

        // Sample ticks after re-init
        for (int i = 0; i < 2500 && tick_total < 2; i++) @(negedge clk);
        check("tick_seen", tick_total >= 2, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
